// File: rtl/branch_pkg.sv
// branch_pkg: funct3 codes, predictor counter encodings and counter type
// shared by the branch resolution unit and its condition evaluator.
package branch_pkg;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational RISC-V conditional-branch evaluation;
// funct3 010/011 are reserved and report illegal with taken forced low.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);
    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = rs1 == rs2;
    assign w_lt  = $signed(rs1) < $signed(rs2);
    assign w_ltu = rs1 < rs2;

    always_comb begin
        illegal = funct3 == 3'b010 || funct3 == 3'b011;
        taken   = funct3 == F3_BEQ  ? w_eq   :
                  funct3 == F3_BNE  ? !w_eq  :
                  funct3 == F3_BLT  ? w_lt   :
                  funct3 == F3_BGE  ? !w_lt  :
                  funct3 == F3_BLTU ? w_ltu  :
                  funct3 == F3_BGEU ? !w_ltu : 1'b0;
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch resolution plus a direct-mapped
// 2-bit predictor table; BRANCH_RESOLVE_STATS_EN adds branch/mispredict counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 16,
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic            res_branch,
    input  logic [2:0]      res_funct3,
    input  logic [PC_W-1:0] res_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            res_pred,
`ifdef BRANCH_RESOLVE_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic            out_valid,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic            out_illegal
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    ctr_t             r_bht [BHT_DEPTH];
    logic             r_valid;
    logic             r_taken;
    logic             r_mispredict;
    logic             r_illegal;
    logic             w_accept;
    logic             w_taken;
    logic             w_illegal;
    logic [IDX_W-1:0] w_pidx;
    logic [IDX_W-1:0] w_ridx;
    ctr_t             w_ctr;
    ctr_t             w_next;
    logic             w_unused;

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .funct3  (res_funct3),
        .rs1     (rs1_data),
        .rs2     (rs2_data),
        .taken   (w_taken),
        .illegal (w_illegal)
    );

    assign w_accept   = res_valid && res_branch;
    assign w_pidx     = pred_pc[IDX_W:1];
    assign w_ridx     = res_pc[IDX_W:1];
    assign w_unused   = ^{pred_pc, res_pc};
    // Table is read before the edge, so a same-index update shows up next cycle.
    assign pred_taken = r_bht[w_pidx][1];

    always_comb begin
        w_ctr  = r_bht[w_ridx];
        w_next = w_taken ? (w_ctr == CTR_ST ? CTR_ST : w_ctr + 2'd1)
                         : (w_ctr == CTR_SNT ? CTR_SNT : w_ctr - 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CTR_WNT;
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_taken      <= w_taken;
                r_mispredict <= w_taken != res_pred;
                r_illegal    <= w_illegal;
                if (!w_illegal) r_bht[w_ridx] <= w_next;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_accept && !w_illegal) begin
            r_stat_branches <= r_stat_branches + 32'd1;
            if (w_taken != res_pred) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

    assign out_valid      = r_valid;
    assign out_taken      = r_taken;
    assign out_mispredict = r_mispredict;
    assign out_illegal    = r_illegal;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit;
// stats checks are included when BRANCH_RESOLVE_STATS_EN is defined.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pred_pc = '0;
    logic        pred_taken;
    logic        res_valid = 1'b0;
    logic        res_branch = 1'b0;
    logic [2:0]  res_funct3 = '0;
    logic [15:0] res_pc = '0;
    logic [15:0] rs1_data = '0;
    logic [15:0] rs2_data = '0;
    logic        res_pred = 1'b0;
    logic        out_valid;
    logic        out_taken;
    logic        out_mispredict;
    logic        out_illegal;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(16), .PC_W(16), .BHT_DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_branch     (res_branch),
        .res_funct3     (res_funct3),
        .res_pc         (res_pc),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .res_pred       (res_pred),
`ifdef BRANCH_RESOLVE_STATS_EN
        .stat_branches  (stat_branches),
        .stat_mispredicts(stat_mispredicts),
`endif
        .out_valid      (out_valid),
        .out_taken      (out_taken),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic br, input logic [2:0] f3, input logic [15:0] pc,
                           input logic [15:0] a, input logic [15:0] b, input logic pr);
        res_valid = 1'b1; res_branch = br; res_funct3 = f3; res_pc = pc;
        rs1_data = a; rs2_data = b; res_pred = pr;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        pred_pc = 16'h0040;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got %b want 0", out_taken); end
        if (out_mispredict !== 1'b0) begin failures++; $display("FAIL reset_mispredict got %b want 0", out_mispredict); end
        if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got %b want 0", out_illegal); end
        if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got %b want 0", pred_taken); end
    endtask

    task automatic test_beq();
        pred_pc = 16'h0040;
        res_valid = 1'b1; res_branch = 1'b1; res_funct3 = 3'b000; res_pc = 16'h0040;
        rs1_data = 16'h1234; rs2_data = 16'h1234; res_pred = 1'b0;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin failures++; $display("FAIL beq_pre_update_pred got %b want 0", pred_taken); end
        tick();
        res_valid = 1'b0;
        checks += 5;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL beq_valid got %b want 1", out_valid); end
        if (out_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got %b want 1", out_taken); end
        if (out_mispredict !== 1'b1) begin failures++; $display("FAIL beq_mispredict got %b want 1", out_mispredict); end
        if (out_illegal !== 1'b0) begin failures++; $display("FAIL beq_illegal got %b want 0", out_illegal); end
        if (pred_taken !== 1'b1) begin failures++; $display("FAIL beq_pred_after got %b want 1", pred_taken); end
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got %b want 0", out_valid); end
        if (out_taken !== 1'b1) begin failures++; $display("FAIL idle_hold_taken got %b want 1", out_taken); end
    endtask

    task automatic test_signed();
        resolve(1'b1, 3'b101, 16'h0010, 16'h8000, 16'h0001, 1'b0);
        checks++;
        if (out_taken !== 1'b0) begin failures++; $display("FAIL bge_neg got %b want 0", out_taken); end
        resolve(1'b1, 3'b111, 16'h0010, 16'h8000, 16'h0001, 1'b0);
        checks += 2;
        if (out_taken !== 1'b1) begin failures++; $display("FAIL bgeu got %b want 1", out_taken); end
        if (out_mispredict !== 1'b1) begin failures++; $display("FAIL bgeu_mispredict got %b want 1", out_mispredict); end
        resolve(1'b1, 3'b101, 16'h0010, 16'h7FFF, 16'h7FFF, 1'b1);
        checks += 2;
        if (out_taken !== 1'b1) begin failures++; $display("FAIL bge_equal got %b want 1", out_taken); end
        if (out_mispredict !== 1'b0) begin failures++; $display("FAIL bge_equal_mispredict got %b want 0", out_mispredict); end
    endtask

    task automatic test_saturate();
        pred_pc = 16'h0006;
        for (int i = 0; i < 4; i++) resolve(1'b1, 3'b000, 16'h0006, 16'h0001, 16'h0001, 1'b1);
        checks++;
        if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_after_4t got %b want 1", pred_taken); end
        resolve(1'b1, 3'b001, 16'h0006, 16'h0001, 16'h0001, 1'b1);
        checks++;
        if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_after_1nt got %b want 1", pred_taken); end
        resolve(1'b1, 3'b001, 16'h0006, 16'h0001, 16'h0001, 1'b1);
        checks++;
        if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_after_2nt got %b want 0", pred_taken); end
    endtask

    task automatic test_back_to_back();
        logic e;
        res_valid = 1'b1; res_branch = 1'b1; res_pc = 16'h0008;
        rs1_data = 16'hFFFF; rs2_data = 16'h0000; res_pred = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res_funct3 = (i % 2 == 1) ? 3'b110 : 3'b100;
            e = (i % 2 == 0);
            tick();
            checks += 3;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
            if (out_taken !== e) begin failures++; $display("FAIL b2b_taken[%0d] got %b want %b", i, out_taken, e); end
            if (out_mispredict !== !e) begin failures++; $display("FAIL b2b_mispredict[%0d] got %b want %b", i, out_mispredict, !e); end
        end
        res_valid = 1'b0;
    endtask

    task automatic test_illegal();
        pred_pc = 16'h000A;
        resolve(1'b1, 3'b010, 16'h000A, 16'h0005, 16'h0005, 1'b1);
        checks += 4;
        if (out_illegal !== 1'b1) begin failures++; $display("FAIL ill010_flag got %b want 1", out_illegal); end
        if (out_taken !== 1'b0) begin failures++; $display("FAIL ill010_taken got %b want 0", out_taken); end
        if (out_mispredict !== 1'b1) begin failures++; $display("FAIL ill010_mispredict got %b want 1", out_mispredict); end
        if (out_valid !== 1'b1) begin failures++; $display("FAIL ill010_valid got %b want 1", out_valid); end
        resolve(1'b1, 3'b011, 16'h000A, 16'h0005, 16'h0006, 1'b0);
        checks++;
        if (out_illegal !== 1'b1) begin failures++; $display("FAIL ill011_flag got %b want 1", out_illegal); end
        resolve(1'b1, 3'b000, 16'h000A, 16'h0005, 16'h0005, 1'b0);
        checks += 2;
        if (out_illegal !== 1'b0) begin failures++; $display("FAIL legal_after_ill got %b want 0", out_illegal); end
        if (pred_taken !== 1'b1) begin failures++; $display("FAIL ill_no_update got %b want 1", pred_taken); end
    endtask

    task automatic test_not_branch();
        pred_pc = 16'h000C;
        resolve(1'b1, 3'b001, 16'h0002, 16'h0001, 16'h0001, 1'b0);
        resolve(1'b0, 3'b000, 16'h000C, 16'h0003, 16'h0003, 1'b0);
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL nobr_valid got %b want 0", out_valid); end
        if (out_taken !== 1'b0) begin failures++; $display("FAIL nobr_hold_taken got %b want 0", out_taken); end
        if (pred_taken !== 1'b0) begin failures++; $display("FAIL nobr_no_update got %b want 0", pred_taken); end
    endtask

    task automatic test_rst_mid();
        pred_pc = 16'h000E;
        resolve(1'b1, 3'b000, 16'h000E, 16'h0001, 16'h0001, 1'b0);
        checks++;
        if (pred_taken !== 1'b1) begin failures++; $display("FAIL rstmid_pretrain got %b want 1", pred_taken); end
        rst = 1'b1;
        resolve(1'b1, 3'b000, 16'h000E, 16'h0001, 16'h0001, 1'b0);
        rst = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        if (out_taken !== 1'b0) begin failures++; $display("FAIL rstmid_taken got %b want 0", out_taken); end
        if (pred_taken !== 1'b0) begin failures++; $display("FAIL rstmid_table got %b want 0", pred_taken); end
        pred_pc = 16'h0040;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin failures++; $display("FAIL rstmid_table40 got %b want 0", pred_taken); end
    endtask

`ifdef BRANCH_RESOLVE_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) resolve(1'b1, 3'b000, 16'h0030, 16'h0009, 16'h0009, i < 7);
        resolve(1'b1, 3'b011, 16'h0030, 16'h0009, 16'h0009, 1'b1);
        resolve(1'b0, 3'b000, 16'h0030, 16'h0009, 16'h0009, 1'b0);
        checks += 2;
        if (stat_branches !== 32'd10) begin failures++; $display("FAIL stat_branches got %0d want 10", stat_branches); end
        if (stat_mispredicts !== 32'd3) begin failures++; $display("FAIL stat_mispredicts got %0d want 3", stat_mispredicts); end
    endtask
`endif

    initial begin
        test_reset();
        test_beq();
        test_signed();
        test_saturate();
        test_back_to_back();
        test_illegal();
        test_not_branch();
        test_rst_mid();
`ifdef BRANCH_RESOLVE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution unit for the multicycle RV core, placed in the execute stage beside the ALU. It evaluates all six RISC-V conditional-branch conditions from the raw operands and registers the taken/not-taken decision. It also keeps a direct-mapped table of 2-bit saturating predictors that fetch queries and execute trains, and flags mispredictions.

## Interface
- XLEN, 16, operand width in bits
- PC_W, 16, program-counter width in bits
- BHT_DEPTH, 16, predictor entries; power of two, minimum 2; IDX_W = $clog2(BHT_DEPTH)
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- pred_pc  in  PC_W  fetch PC to look up
- pred_taken  out  1  combinational prediction: MSB of the counter at index(pred_pc)
- res_valid  in  1  single-cycle pulse; a branch is presented for resolution
- res_branch  in  1  instruction is a conditional branch; if 0 the pulse is ignored
- res_funct3  in  3  RISC-V branch funct3
- res_pc  in  PC_W  PC of the resolving branch
- rs1_data, rs2_data  in  XLEN each  comparison operands
- res_pred  in  1  prediction fetch used for this branch
- out_valid  out  1  result valid, one cycle after an accepted res_valid
- out_taken  out  1  resolved direction
- out_mispredict  out  1  out_taken != res_pred (registered)
- out_illegal  out  1  funct3 was 010 or 011

## Operation
- Index: index(pc) = pc[IDX_W:1] (halfword-aligned PCs).
- Accept condition: res_valid && res_branch.
- Condition decode:
  - 000 BEQ: rs1 == rs2
  - 001 BNE: rs1 != rs2
  - 100 BLT: signed rs1 < rs2
  - 101 BGE: signed rs1 >= rs2 (equality counts as taken)
  - 110 BLTU: unsigned rs1 < rs2
  - 111 BGEU: unsigned rs1 >= rs2
  - 010/011: taken = 0, illegal = 1, no predictor update
- Signed comparison uses full XLEN two's complement; no wrap or overflow path.
- Predictor: per entry, 2-bit saturating counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
  - On accepted legal resolve, counter at index(res_pc) increments if taken (saturates at 11), else decrements (saturates at 00).
- Output registers: out_taken, out_mispredict and out_illegal load only on accept and hold until the next accept. out_valid is set on accept and cleared otherwise.
- No internal FSM beyond output and table registers. A new accept every cycle is legal: full throughput, no backpressure.

## Timing
- Reset:
  - all counters = 01
  - out_valid = 0, out_taken = 0, out_mispredict = 0, out_illegal = 0
- Resolve latency: accept at edge N, outputs valid after edge N (visible in cycle N+1).
- pred_taken: zero-latency combinational read.
- Read/write conflict: when pred_pc and res_pc map to the same index in the same cycle, pred_taken returns the pre-update value. The update is visible in the following cycle.
- Reset mid-operation: rst asserted in the same cycle as res_valid has priority. The result is dropped, the table is reinitialised and out_valid = 0.
- res_valid with res_branch = 0: no state change; out_valid = 0 next cycle.

## Configuration
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined, adds two outputs:
  - stat_branches (32-bit): count of accepted legal branches
  - stat_mispredicts (32-bit): count of those with out_mispredict
- Both counters are cleared by rst and wrap modulo 2^32. They update on the same edge as the output registers.
- When undefined, neither the ports nor the counters exist. All other behaviour is identical.

## Structure
- Shared package branch_pkg holds:
  - localparams for funct3 codes F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - counter constants CTR_SNT, CTR_WNT, CTR_WT, CTR_ST
  - typedef ctr_t (logic [1:0])
- One sub-module, branch_cond_eval: purely combinational funct3 + operands -> {taken, illegal}. It is reused by any future compressed-branch path.
- The table is a flat register array. No RAM macro is used, because of the same-cycle read requirement.

## Test plan
- After rst, pred_pc = 0x0040 -> pred_taken = 0. Resolve BEQ at 0x0040, rs1 = rs2 = 0x1234, res_pred = 0 -> next cycle out_taken = 1, out_mispredict = 1, and the counter moves to 10 (pred_taken = 1 thereafter).
- BGE signed, rs1 = 0x8000, rs2 = 0x0001 -> taken 0. BGEU with the same operands -> taken 1. BGE with rs1 = rs2 = 0x7FFF -> taken 1.
- Four consecutive taken resolves at one PC -> counter saturates at 11. Two not-taken -> 01, pred_taken = 0.
- Back-to-back accepts every cycle alternating BLT/BLTU with rs1 = 0xFFFF, rs2 = 0x0000 -> out_taken sequence 1, 0, 1, 0, with out_valid held at 1.
- funct3 = 010 -> out_illegal = 1, out_taken = 0, predictor entry unchanged. Also check rst asserted together with res_valid -> out_valid = 0 and the table is back at 01.
- With BRANCH_RESOLVE_STATS_EN defined: 10 resolves with 3 mispredicts plus one illegal -> stat_branches = 10, stat_mispredicts = 3.
